// File: rtl/drp_reconf_master.sv
// rtl/drp_reconf_master.sv - DRP read-modify-write master that reprograms a PLL from a two-bank ROM
// Optional verify read after each write: DRP_READBACK_EN. The ROM image is passed in as ROM_IMAGE.
module drp_reconf_master #(
  parameter int NUM_ENTRIES = 23,
  parameter int TIMEOUT     = 255,
  parameter logic [2*NUM_ENTRIES*39-1:0] ROM_IMAGE = '0
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        SEN,
  input  logic        SADDR,
  output logic        SRDY,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        RST_PLL
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int AW = $clog2(2 * NUM_ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    RESTART, WAIT_LOCK, WAIT_SEN, ADDRESS, WAIT_A_DRDY,
    BITMASK, BITSET, WRITE, WAIT_W_DRDY
`ifdef DRP_READBACK_EN
    , VERIFY, WAIT_V_DRDY
`endif
  } state_t;

  state_t          state_q;
  logic            bank_q;
  logic [IW-1:0]   index_q;
  logic [7:0]      tmo_q;
  logic [15:0]     rdata_q;
  logic [6:0]      daddr_q;
  logic [15:0]     di_q;
  logic            den_q, dwe_q, srdy_q, err_q, rst_pll_q;

  logic [38:0]     rom [2*NUM_ENTRIES];
  logic [AW-1:0]   rom_idx;
  logic [38:0]     rom_word;
  logic            drdy_ok, tmo_hit;

  for (genvar g = 0; g < 2 * NUM_ENTRIES; g++) begin : g_rom
    assign rom[g] = ROM_IMAGE[g*39 +: 39];
  end

  assign rom_idx  = AW'(index_q) + (bank_q ? AW'(NUM_ENTRIES) : AW'(0));
  assign rom_word = rom[rom_idx];
  // An acknowledge seen while our own DEN is still high belongs to nothing we issued.
  assign drdy_ok  = DRDY & ~den_q;
  assign tmo_hit  = (tmo_q == TMO_LAST);

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q   <= RESTART;
      bank_q    <= 1'b0;
      index_q   <= '0;
      tmo_q     <= '0;
      rdata_q   <= '0;
      daddr_q   <= '0;
      di_q      <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      srdy_q    <= 1'b0;
      err_q     <= 1'b0;
      rst_pll_q <= 1'b1;
    end else begin
      den_q  <= 1'b0;
      dwe_q  <= 1'b0;
      srdy_q <= 1'b0;
      case (state_q)
        RESTART: begin
          rst_pll_q <= 1'b0;
          state_q   <= WAIT_LOCK;
        end
        WAIT_LOCK: if (LOCKED) begin
          srdy_q  <= 1'b1;
          state_q <= WAIT_SEN;
        end
        WAIT_SEN: if (SEN) begin
          bank_q    <= SADDR;
          index_q   <= '0;
          err_q     <= 1'b0;
          rst_pll_q <= 1'b1;
          state_q   <= ADDRESS;
        end
        ADDRESS: begin
          daddr_q <= rom_word[38:32];
          den_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_A_DRDY;
        end
        WAIT_A_DRDY: begin
          if (drdy_ok) begin
            rdata_q <= DO;
            state_q <= BITMASK;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= RESTART;
          end else tmo_q <= tmo_q + 8'd1;
        end
        BITMASK: begin
          rdata_q <= rdata_q & rom_word[31:16];
          state_q <= BITSET;
        end
        BITSET: begin
          rdata_q <= rdata_q | (rom_word[15:0] & ~rom_word[31:16]);
          state_q <= WRITE;
        end
        WRITE: begin
          di_q    <= rdata_q;
          den_q   <= 1'b1;
          dwe_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_W_DRDY;
        end
        WAIT_W_DRDY: begin
          if (drdy_ok) begin
`ifdef DRP_READBACK_EN
            state_q <= VERIFY;
`else
            if (index_q == LAST_IDX) state_q <= RESTART;
            else begin
              index_q <= index_q + 1'b1;
              state_q <= ADDRESS;
            end
`endif
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= RESTART;
          end else tmo_q <= tmo_q + 8'd1;
        end
`ifdef DRP_READBACK_EN
        VERIFY: begin
          den_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_V_DRDY;
        end
        WAIT_V_DRDY: begin
          if (drdy_ok) begin
            if (DO != di_q) err_q <= 1'b1;
            if (index_q == LAST_IDX) state_q <= RESTART;
            else begin
              index_q <= index_q + 1'b1;
              state_q <= ADDRESS;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= RESTART;
          end else tmo_q <= tmo_q + 8'd1;
        end
`endif
        default: state_q <= RESTART;
      endcase
    end
  end

  assign SRDY    = srdy_q;
  assign ERR     = err_q;
  assign DADDR   = daddr_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign DI      = di_q;
  assign RST_PLL = rst_pll_q;

endmodule

// File: tb/tb_drp_reconf_master.sv
// tb/tb_drp_reconf_master.sv - directed scoreboard bench for drp_reconf_master
module tb_drp_reconf_master;

  localparam int NE = 23;
`ifdef DRP_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } xact_t;

  function automatic logic [6:0] ent_addr(input int b, input int i);
    return 7'(8 + 32 * b + i);
  endfunction

  function automatic logic [15:0] ent_mask(input int b, input int i);
    return 16'hF000 ^ 16'(i * 16'h0111) ^ ((b != 0) ? 16'h0F0F : 16'h0000);
  endfunction

  function automatic logic [15:0] ent_data(input int b, input int i);
    return 16'h0041 ^ 16'(i * 16'h0123) ^ ((b != 0) ? 16'h5A00 : 16'h0000);
  endfunction

  function automatic logic [2*NE*39-1:0] build_img();
    logic [2*NE*39-1:0] img;
    img = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NE; i++)
        img[(b*NE+i)*39 +: 39] = {ent_addr(b, i), ent_mask(b, i), ent_data(b, i)};
    return img;
  endfunction

  function automatic logic [15:0] mem_init(input int a);
    return 16'hA5C3 ^ 16'(a * 16'h0101) ^ 16'h0808;
  endfunction

  localparam logic [2*NE*39-1:0] IMG = build_img();

  logic        DCLK = 1'b0;
  logic        RST, SEN, SADDR, LOCKED;
  logic        SRDY, ERR, DEN, DWE, RST_PLL;
  logic        DRDY;
  logic [6:0]  DADDR;
  logic [15:0] DI, DO;

  drp_reconf_master #(.NUM_ENTRIES(NE), .TIMEOUT(255), .ROM_IMAGE(IMG)) dut (
    .DCLK(DCLK), .RST(RST), .SEN(SEN), .SADDR(SADDR), .SRDY(SRDY), .ERR(ERR),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .LOCKED(LOCKED), .RST_PLL(RST_PLL)
  );

  always #5 DCLK = ~DCLK;

  int          tests = 0;
  int          fails = 0;
  xact_t       exp_q[$];
  logic [15:0] sh [128];
  int          nrd, nwr;
  logic [15:0] first_wr;
  logic        den_prev = 1'b0;
  logic        stuck = 1'b0;
  logic        corrupt = 1'b0;

  // DRP responder: acknowledges one cycle after the DEN cycle.
  logic [15:0] mem [128];
  logic        mem_ok = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] pend_data;
  always @(posedge DCLK) begin
    #1;
    DRDY = 1'b0;
    if (RST === 1'b1) begin
      pend = 1'b0;
      DO   = 16'h0;
      if (!mem_ok) begin
        for (int a = 0; a < 128; a++) mem[a] = mem_init(a);
        mem_ok = 1'b1;
      end
    end else begin
      if (pend && !stuck) begin
        DRDY = 1'b1;
        DO   = pend_data;
      end
      if (stuck) pend = 1'b0;
      else pend = 1'b0;
      if (DEN === 1'b1) begin
        if (DWE === 1'b1) mem[DADDR] = corrupt ? (DI ^ 16'h0001) : DI;
        pend_data = mem[DADDR];
        pend      = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    xact_t e;
    if (RST !== 1'b0) begin
      den_prev = 1'b0;
      return;
    end
    if (DEN === 1'b1) begin
      chk("den_back_to_back", 32'(den_prev), 0);
      chk("rst_pll_during_access", 32'(RST_PLL), 1);
      chk("sb_unexpected_den", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_we_addr", {24'h0, DWE, DADDR}, {24'h0, e.we, e.addr});
        if (e.we) chk("sb_wdata", 32'(DI), 32'(e.data));
      end
      if (DWE === 1'b1) begin
        if (nwr == 0) first_wr = DI;
        nwr++;
      end else nrd++;
    end
    if (DWE === 1'b1) chk("dwe_without_den", 32'(DEN), 1);
    den_prev = DEN;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge DCLK);
      monitor();
    end
    #1;
  endtask

  task automatic push_entry(input int b, input int i);
    logic [6:0]  a;
    logic [15:0] w;
    a = ent_addr(b, i);
    w = (sh[a] & ent_mask(b, i)) | (ent_data(b, i) & ~ent_mask(b, i));
    sh[a] = w;
    exp_q.push_back({1'b0, a, 16'h0});
    exp_q.push_back({1'b1, a, w});
`ifdef DRP_READBACK_EN
    exp_q.push_back({1'b0, a, 16'h0});
`endif
  endtask

  task automatic start(input logic bank);
    nrd = 0;
    nwr = 0;
    SADDR = bank;
    SEN = 1'b1;
    tick(1);
    SEN = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic srdy_count(input int n, output int c);
    c = 0;
    repeat (n) begin
      if (SRDY === 1'b1) c++;
      tick(1);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_daddr", 32'(DADDR), 0);
    chk("rst_den", 32'(DEN), 0);
    chk("rst_dwe", 32'(DWE), 0);
    chk("rst_di", 32'(DI), 0);
    chk("rst_srdy", 32'(SRDY), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_rst_pll", 32'(RST_PLL), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    RST = 1'b1; SEN = 1'b0; SADDR = 1'b0; LOCKED = 1'b0;
    for (int a = 0; a < 128; a++) sh[a] = mem_init(a);
    nrd = 0; nwr = 0; first_wr = 16'h0;
    tick(3);
    chk_reset_values();

    // Bring-up: PLL released, SRDY once LOCKED arrives
    RST = 1'b0;
    tick(4);
    chk("rst_pll_released", 32'(RST_PLL), 0);
    chk("srdy_before_lock", 32'(SRDY), 0);
    LOCKED = 1'b1;
    srdy_count(8, c);
    chk("srdy_after_lock", 32'(c), 1);

    // Bank 0: first entry {0x08, 0xF000, 0x0041} over 0xA5C3 must write 0xA041
    for (int i = 0; i < NE; i++) push_entry(0, i);
    start(1'b0);
    tick(2);
    chk("rst_pll_in_seq", 32'(RST_PLL), 1);
    wait_empty("bank0_done", 2000);
    chk("bank0_first_wdata", 32'(first_wr), 32'h0000A041);
    chk("bank0_reads", 32'(nrd), 32'(NE * (1 + RB)));
    chk("bank0_writes", 32'(nwr), 32'(NE));
    srdy_count(12, c);
    chk("bank0_srdy", 32'(c), 1);
    chk("bank0_rst_pll_low", 32'(RST_PLL), 0);
    chk("bank0_err", 32'(ERR), 0);

    // Bank 1, with a stray SEN mid-sequence that must be ignored
    for (int i = 0; i < NE; i++) push_entry(1, i);
    start(1'b1);
    SADDR = 1'b0;
    tick(20);
    SEN = 1'b1;
    tick(1);
    SEN = 1'b0;
    wait_empty("bank1_done", 2000);
    chk("bank1_reads", 32'(nrd), 32'(NE * (1 + RB)));
    chk("bank1_writes", 32'(nwr), 32'(NE));
    srdy_count(12, c);
    chk("bank1_srdy", 32'(c), 1);
    chk("bank1_err", 32'(ERR), 0);

    // DRDY never arrives: timeout after 255 cycles
    stuck = 1'b1;
    exp_q.push_back({1'b0, ent_addr(0, 0), 16'h0});
    start(1'b0);
    wait_empty("tmo_first_den", 20);
    n = 0;
    while (ERR !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk("tmo_cycles_in_window", 32'(n >= 254 && n <= 256), 1);
    chk("tmo_den_low", 32'(DEN), 0);
    srdy_count(10, c);
    chk("tmo_srdy_relock", 32'(c), 1);
    chk("tmo_rst_pll_low", 32'(RST_PLL), 0);
    chk("tmo_err_sticky", 32'(ERR), 1);
    stuck = 1'b0;
    tick(2);

    // RST during WAIT_W_DRDY of entry 5, then a clean restart from entry 0
    for (int i = 0; i < 6; i++) push_entry(0, i);
`ifdef DRP_READBACK_EN
    void'(exp_q.pop_back());
`endif
    start(1'b0);
    chk("sen_clears_err", 32'(ERR), 0);
    wait_empty("entry5_write", 400);
    chk("entry5_is_write", 32'(DWE), 1);
    RST = 1'b1;
    #1;
    chk_reset_values();
    tick(2);
    RST = 1'b0;
    srdy_count(8, c);
    chk("post_rst_srdy", 32'(c), 1);
    for (int i = 0; i < NE; i++) push_entry(0, i);
    start(1'b0);
    wait_empty("restart_done", 2000);
    chk("restart_writes", 32'(nwr), 32'(NE));
    srdy_count(12, c);
    chk("restart_srdy", 32'(c), 1);
    chk("restart_err", 32'(ERR), 0);

`ifdef DRP_READBACK_EN
    // Responder corrupts bit 0 on write: ERR set, sequence still completes
    corrupt = 1'b1;
    for (int i = 0; i < NE; i++) push_entry(1, i);
    start(1'b1);
    wait_empty("readback_done", 3000);
    tick(12);
    chk("readback_err", 32'(ERR), 1);
    chk("readback_writes", 32'(nwr), 32'(NE));
    corrupt = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
